serial_add_sub: RTL

//   Bit-serial N-bit unsigned adder / two's-complement subtractor with valid/ready handshakes.
//   It is the sequential, area-lean counterpart of the combinational N-bit adder/subtractor.
//   It uses one full-adder cell plus shift registers and processes one bit per clock, LSB first.
//   It sits between an operand producer and a result consumer, which can both stall it.
//

---
 rtl/serial_add_sub.sv | 105 ++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial N-bit adder / two's-complement subtractor.
// One full-adder cell consumes one operand bit per clock, LSB first, between
// a valid/ready operand interface and a valid/ready result interface.
module serial_add_sub #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_sum;
  logic            r_carry;
  logic            r_op;
  logic [CW-1:0]   r_cnt;
  logic [N:0]      r_result;

  logic            w_s;
  logic            w_c;
  logic            w_last;
  logic [N:0]      w_cat;
  logic [N-1:0]    w_sum_next;

  // Full-adder cell on the current LSBs and the sum register shifted right
  // with the new bit entering at the top (concatenate-then-slice keeps N=1 legal).
  always_comb begin
    w_s        = r_a[0] ^ r_b[0] ^ r_carry;
    w_c        = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    w_cat      = {w_s, r_sum};
    w_sum_next = w_cat[N:1];
    w_last     = (r_cnt == CW'(N - 1));
  end

  // Control FSM and datapath registers; the result is captured on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {N{sub}};
            r_carry <= sub;
            r_op    <= sub;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          r_sum   <= w_sum_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            // Subtraction carry-out is the inverted borrow, so flip it for the sign bit.
            r_result <= {(r_op ? ~w_c : w_c), w_sum_next};
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    result    = r_result;
  end

endmodule
